// File: rtl/seq_11011_frame_tx.sv
// seq_11011_frame_tx: serial frame transmitter sending sync word, MSB-first payload, optional even parity, then an idle gap
module seq_11011_frame_tx #(
  parameter int SYNC_LEN = 5,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = 5'b11011,
  parameter int GAP_LEN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int MX = SYNC_LEN > 8 ? (SYNC_LEN > GAP_LEN ? SYNC_LEN : GAP_LEN) : (GAP_LEN > 8 ? GAP_LEN : 8);
  localparam int CW = $clog2(MX);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic par_en, par_en_n, par, par_n;
  logic [3:0] fcnt, fcnt_n;
  logic [3:0] oq;
  logic [SYNC_LEN-1:0] sw_sh;
  logic sout_n, valid_n, busy_n, done_n, last, start, unused_bits;
  assign start = uio_in[0];
  assign last = cnt == '0;
  assign unused_bits = ^uio_in[7:2];
  assign uo_out = {fcnt, oq};
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    par_en_n = par_en;
    par_n = par;
    fcnt_n = fcnt;
    case (state)
      IDLE: if (start) begin
        state_n = SYNC;
        cnt_n = CW'(SYNC_LEN - 1);
        sh_n = ui_in;
        par_en_n = uio_in[1];
        par_n = ^ui_in;
      end
      SYNC: begin
        state_n = last ? DATA : SYNC;
        cnt_n = last ? CW'(7) : cnt - 1'b1;
      end
      DATA: begin
        sh_n = {sh[6:0], 1'b0};
        cnt_n = last ? CW'(GAP_LEN - 1) : cnt - 1'b1;
        state_n = !last ? DATA : par_en ? PARITY : GAP;
        fcnt_n = (last && !par_en) ? fcnt + 4'd1 : fcnt;
      end
      PARITY: begin
        state_n = GAP;
        cnt_n = CW'(GAP_LEN - 1);
        fcnt_n = fcnt + 4'd1;
      end
      GAP: begin
        state_n = last ? IDLE : GAP;
        cnt_n = last ? cnt : cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // outputs are decoded from next-state values so they leave the block straight from flops
    sw_sh = SYNC_WORD >> cnt_n;
    sout_n = state_n == SYNC ? sw_sh[0] : state_n == DATA ? sh_n[7] : state_n == PARITY ? par_n : 1'b0;
    valid_n = state_n == SYNC || state_n == DATA || state_n == PARITY;
    busy_n = state_n != IDLE;
    done_n = state_n == GAP && state != GAP;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      par_en <= 1'b0;
      par <= 1'b0;
      fcnt <= '0;
      oq <= '0;
    end else if (ena) begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      par_en <= par_en_n;
      par <= par_n;
      fcnt <= fcnt_n;
      oq <= {done_n, busy_n, valid_n, sout_n};
    end
  end
endmodule

// File: tb/tb_seq_11011_frame_tx.sv
// tb_seq_11011_frame_tx: vector table, directed corner sequences and a random run against a frame-level queue model
module tb_seq_11011_frame_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [3:0] q[$];
  logic [3:0] m_out = 4'h0;
  logic [3:0] m_fc = 4'h0;
  logic [4:0] sw = 5'b11011;
  typedef struct {
    logic [7:0] d;
    bit p;
    logic [15:0] exp;
    int len;
  } vec_t;
  vec_t tbl[6];

  seq_11011_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Frame model: on acceptance, the whole frame is expanded into one {done,busy,valid,sout} record per cycle
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_fc = 4'h0;
      m_out = 4'h0;
    end else if (ena) begin
      if (q.size() == 0) begin
        m_out = 4'h0;
        if (uio_in[0]) begin
          for (int i = 4; i >= 0; i--) q.push_back({3'b011, sw[i]});
          for (int i = 7; i >= 0; i--) q.push_back({3'b011, ui_in[i]});
          if (uio_in[1]) q.push_back({3'b011, ^ui_in});
          q.push_back(4'b1100);
          q.push_back(4'b0100);
          q.push_back(4'b0000);
        end
      end
      if (q.size() > 0) begin
        m_out = q.pop_front();
        if (m_out[3]) m_fc = m_fc + 4'd1;
      end
    end
    #1;
    if (chk_en) chk("model", {uo_out, uio_out, uio_oe}, {m_fc, m_out, 16'h0000});
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, output logic [15:0] bits, output int n,
                            output int dcnt, output bit dok, output int fires, output bit hit);
    logic [4:0] win;
    bit seen, pv;
    win = '0; bits = '0; n = 0; dcnt = 0; dok = 0; fires = 0; hit = 0; seen = 0; pv = 0;
    @(negedge clk);
    ui_in = d;
    uio_in = {6'b0, p, 1'b1};
    @(negedge clk);
    uio_in[0] = 1'b0;
    ui_in = 8'($urandom);
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      win = {win[3:0], uo_out[0]};
      if (uo_out[1]) begin
        bits = {bits[14:0], uo_out[0]};
        n++;
      end
      if (win == 5'b11011) begin
        fires++;
        if (uo_out[1] && n == 5) hit = 1;
      end
      if (uo_out[3]) begin
        dcnt++;
        dok = pv && !uo_out[1];
      end
      pv = uo_out[1];
      seen |= uo_out[2];
      if (seen && !uo_out[2]) break;
    end
    chk("frame_end", {31'b0, seen && !uo_out[2]}, 1);
  endtask

  initial begin
    logic [15:0] bits;
    int n, dcnt, fires, rises, t_last, bcyc, vcyc;
    bit dok, hit, pv;
    logic [7:0] held;
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int n, dcnt, fires, rises, t_last, bcyc, vcyc;
    bit dok, hit, pv;
    logic [7:0] held;
    tbl[0] = '{8'hA5, 1'b0, 16'b1101110100101, 13};
    tbl[1] = '{8'h00, 1'b0, 16'b1101100000000, 13};
    tbl[2] = '{8'hFF, 1'b0, 16'b1101111111111, 13};
    tbl[3] = '{8'h36, 1'b0, 16'b1101100110110, 13};
    tbl[4] = '{8'h07, 1'b1, 16'b11011000001111, 14};
    tbl[5] = '{8'h03, 1'b1, 16'b11011000000110, 14};
    // reset with ena low must still clear everything
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_uo", uo_out, 8'h00);
    ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].d, tbl[i].p, bits, n, dcnt, dok, fires, hit);
      chk($sformatf("len_%0d", i), n, tbl[i].len);
      chk($sformatf("bits_%0d", i), bits, tbl[i].exp);
      chk($sformatf("done_cnt_%0d", i), dcnt, 1);
      chk($sformatf("done_pos_%0d", i), {31'b0, dok}, 1);
      chk($sformatf("sync_hit_%0d", i), {31'b0, hit}, 1);
      if (tbl[i].d == 8'h00) chk("fires_00", fires, 1);
      if (i == 0) chk("frame_cnt_1", uo_out[7:4], 4'd1);
    end
    chk("frame_cnt_6", uo_out[7:4], 4'd6);

    // back-to-back with start held high, 17 frames to wrap the counter
    do_reset();
    uio_in = 8'h01;
    rises = 0; t_last = 0; pv = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ui_in = 8'($urandom);
      if (uo_out[1] && !pv) begin
        rises++;
        if (rises > 1) chk("period", c - t_last, 16);
        t_last = c;
        if (rises == 17) uio_in[0] = 1'b0;
      end
      pv = uo_out[1];
      if (rises == 17 && !uo_out[2]) break;
    end
    chk("b2b_frames", rises, 17);
    chk("b2b_busy_low", uo_out[2], 0);
    chk("frame_cnt_wrap", uo_out[7:4], 4'd1);

    // freeze for 3 cycles while DATA bit 4 is on the line
    @(negedge clk);
    ui_in = 8'hA5;
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    bcyc = 0; vcyc = 0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (uo_out[2]) bcyc++;
      if (uo_out[1]) vcyc++;
      if (vcyc == 10 && uo_out[1] && ena) begin
        held = uo_out;
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("freeze_hold", uo_out, held);
          if (uo_out[2]) bcyc++;
          if (uo_out[1]) vcyc++;
        end
        ena = 1'b1;
      end
      if (bcyc > 0 && !uo_out[2]) break;
    end
    chk("freeze_busy_len", bcyc, 18);
    chk("freeze_valid_len", vcyc, 16);

    // reset while the third sync bit is showing
    @(negedge clk);
    ui_in = 8'hFF;
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    vcyc = 0;
    for (int c = 0; c < 20 && vcyc < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (uo_out[1]) vcyc++;
    end
    chk("sync2_reached", vcyc, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_uo", uo_out, 8'h00);
    rst_n = 1'b1;
    send_frame(8'hFF, 1'b0, bits, n, dcnt, dok, fires, hit);
    chk("after_reset_len", n, 13);
    chk("after_reset_bits", bits, 16'b1101111111111);

    // random traffic, enables and occasional resets against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      ena = $urandom_range(0, 9) != 0;
      rst_n = $urandom_range(0, 99) != 0;
      ui_in = 8'($urandom);
      uio_in = {6'($urandom), 1'($urandom), $urandom_range(0, 2) == 0};
    end
    @(negedge clk);
    ena = 1'b1;
    rst_n = 1'b1;
    uio_in = 8'h00;
    repeat (25) @(negedge clk);
    chk("final_idle", uo_out[3:0], 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
